regfile_wen_scoreboard: RTL and testbench

Parametrised successor to the combinational register-file write-enable decoder. It tracks in-flight writes per architectural register using busy bits, and stalls issue of a second write to a register that is already busy (WAW). On commit it drives a registered one-hot write-enable vector into the register file. It sits between the decode/issue stage and the register file write port.

---
 rtl/regfile_wen_scoreboard_if.sv | 26 ++
 rtl/regfile_wen_scoreboard.sv | 78 +++++++
 tb/tb_regfile_wen_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wen_scoreboard_if.sv
// Issue/commit handshake and register-file status bundle for regfile_wen_scoreboard.
// Handshake: an issue transfers on a clock edge where issue_valid && issue_ready; commit has no back-pressure.
interface regfile_wen_scoreboard_if #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_addr;
  logic                issue_ready;
  logic                commit_valid;
  logic [ADDR_W-1:0]   commit_addr;
  logic [NUM_REGS-1:0] enable_me;
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W:0]     busy_count;
  logic                err;

  modport master (
    output issue_valid, issue_addr, commit_valid, commit_addr,
    input  issue_ready, enable_me, busy, busy_count, err
  );

  modport slave (
    input  issue_valid, issue_addr, commit_valid, commit_addr,
    output issue_ready, enable_me, busy, busy_count, err
  );
endinterface

// File: rtl/regfile_wen_scoreboard.sv
// WAW scoreboard with busy bits and a registered one-hot register-file write enable.
// Optional macro SCB_SAME_CYCLE_RELEASE_EN lets a same-cycle commit release a register to a new issue.
module regfile_wen_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_RO  = 1
) (
  input  logic clock,
  input  logic reset,
  regfile_wen_scoreboard_if.slave bus
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] enable_q;
  logic [NUM_REGS-1:0] enable_nxt;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_nxt;
  logic                err_q;
  logic                issue_zero;
  logic                commit_zero;
  logic                issue_acc;
  logic                commit_hit;
  logic                commit_miss;

  assign issue_zero  = (ZERO_RO != 0) && (bus.issue_addr == '0);
  assign commit_zero = (ZERO_RO != 0) && (bus.commit_addr == '0);

`ifdef SCB_SAME_CYCLE_RELEASE_EN
  logic same_addr;
  assign same_addr       = bus.commit_valid && (bus.commit_addr == bus.issue_addr);
  assign bus.issue_ready = !busy_q[bus.issue_addr] || same_addr;
`else
  assign bus.issue_ready = !busy_q[bus.issue_addr];
`endif

  assign issue_acc   = bus.issue_valid && bus.issue_ready;
  assign commit_hit  = bus.commit_valid && busy_q[bus.commit_addr];
  // A commit to hardwired r0 is neither a write nor an error.
  assign commit_miss = bus.commit_valid && !busy_q[bus.commit_addr] && !commit_zero;

  // Clear from the commit first so a same-cycle issue to the same register re-reserves it.
  always_comb begin
    busy_nxt   = busy_q;
    enable_nxt = '0;
    count_nxt  = '0;
    if (commit_hit) begin
      busy_nxt[bus.commit_addr]   = 1'b0;
      enable_nxt[bus.commit_addr] = 1'b1;
    end
    if (issue_acc && !issue_zero) begin
      busy_nxt[bus.issue_addr] = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      count_nxt = count_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      enable_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_nxt;
      enable_q <= enable_nxt;
      count_q  <= count_nxt;
      err_q    <= err_q | commit_miss;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.enable_me  = enable_q;
  assign bus.busy_count = count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_regfile_wen_scoreboard.sv
// Randomized and directed bench for regfile_wen_scoreboard with a queue-based scoreboard.
// Honors SCB_SAME_CYCLE_RELEASE_EN when the same macro is defined for the RTL.
module tb_regfile_wen_scoreboard;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_RO  = 1;
`ifdef SCB_SAME_CYCLE_RELEASE_EN
  localparam bit SAME_EN = 1'b1;
`else
  localparam bit SAME_EN = 1'b0;
`endif

  typedef struct {
    int                  due;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] en;
    logic [ADDR_W:0]     cnt;
    logic                err;
  } exp_t;

  // clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  regfile_wen_scoreboard_if #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

  regfile_wen_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_RO(ZERO_RO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard state
  logic [0:0] exp_q[$];
  exp_t       st_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  // reference model: set of reserved registers plus sticky error
  bit mbusy[NUM_REGS];
  bit merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) mbusy[i] = 1'b0;
    merr = 1'b0;
  endtask

  task automatic drive_idle();
    bus.issue_valid  = 1'b0;
    bus.issue_addr   = '0;
    bus.commit_valid = 1'b0;
    bus.commit_addr  = '0;
  endtask

  // driver: one call per clock cycle, predicts ready now and state after the next edge
  task automatic step(input bit iv, input int ia, input bit cv, input int ca);
    exp_t e;
    bit   rdy;
    int   n;
    @(posedge clock);
    #1;
    bus.issue_valid  = iv;
    bus.issue_addr   = ADDR_W'(ia);
    bus.commit_valid = cv;
    bus.commit_addr  = ADDR_W'(ca);
    rdy = !mbusy[ia] || (SAME_EN && cv && (ca == ia));
    exp_q.push_back(rdy);
    e.en = '0;
    if (cv && !(ZERO_RO != 0 && ca == 0)) begin
      if (mbusy[ca]) begin
        mbusy[ca] = 1'b0;
        e.en[ca]  = 1'b1;
      end else begin
        merr = 1'b1;
      end
    end
    if (iv && rdy && !(ZERO_RO != 0 && ia == 0)) mbusy[ia] = 1'b1;
    n = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      e.busy[i] = mbusy[i];
      n += int'(mbusy[i]);
    end
    e.cnt = (ADDR_W + 1)'(n);
    e.err = merr;
    e.due = cyc + 1;
    st_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mbusy[i]) step(1'b0, 0, 1'b1, i);
    end
    step(1'b0, 0, 1'b0, 0);
  endtask

  // monitor: combinational ready, sampled mid-cycle
  initial begin
    logic [0:0] r;
    forever begin
      @(negedge clock);
      if (mon_en && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("issue_ready", 64'(bus.issue_ready), 64'(r));
      end
    end
  end

  // monitor: registered outputs, sampled shortly after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      while (mon_en && st_q.size() > 0 && st_q[0].due <= cyc) begin
        e = st_q.pop_front();
        chk("due_cycle", 64'(cyc), 64'(e.due));
        chk("busy", 64'(bus.busy), 64'(e.busy));
        chk("enable_me", 64'(bus.enable_me), 64'(e.en));
        chk("busy_count", 64'(bus.busy_count), 64'(e.cnt));
        chk("err", 64'(bus.err), 64'(e.err));
      end
    end
  end

  initial begin
    int ia, ca, r, start;
    bit iv, cv;
    drive_idle();
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_enable", 64'(bus.enable_me), 64'd0);
    chk("reset_count", 64'(bus.busy_count), 64'd0);
    chk("reset_err", 64'(bus.err), 64'd0);
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    step(1'b0, 0, 1'b0, 0);
    // basic reserve then commit of r5
    step(1'b1, 5, 1'b0, 0);
    step(1'b0, 0, 1'b1, 5);
    step(1'b0, 0, 1'b0, 0);
    // WAW stall on r9
    step(1'b1, 9, 1'b0, 0);
    step(1'b1, 9, 1'b0, 0);
    step(1'b1, 9, 1'b1, 9);
    step(1'b1, 9, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);
    drain();
    // same-cycle issue and commit on busy r12
    step(1'b1, 12, 1'b0, 0);
    step(1'b1, 12, 1'b1, 12);
    step(1'b1, 12, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);
    drain();
    // fill all writable registers, then release in order
    for (int i = 1; i < NUM_REGS; i++) step(1'b1, i, 1'b0, 0);
    for (int i = 1; i < NUM_REGS; i++) step(1'b0, 0, 1'b1, i);
    step(1'b0, 0, 1'b0, 0);
    // stray commit, then hardwired r0
    step(1'b0, 0, 1'b1, 20);
    step(1'b0, 0, 1'b0, 0);
    step(1'b1, 0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    step(1'b1, 0, 1'b1, 0);
    step(1'b0, 0, 1'b0, 0);

    // asynchronous reset while r3/r7 reserved and an enable is on the wire
    step(1'b1, 3, 1'b0, 0);
    step(1'b1, 7, 1'b0, 0);
    step(1'b0, 0, 1'b1, 3);
    @(posedge clock);
    #3;
    mon_en = 1'b0;
    exp_q.delete();
    st_q.delete();
    drive_idle();
    reset = 1'b1;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_enable", 64'(bus.enable_me), 64'd0);
    chk("async_count", 64'(bus.busy_count), 64'd0);
    chk("async_err", 64'(bus.err), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #2;
    chk("post_reset_enable", 64'(bus.enable_me), 64'd0);
    chk("post_reset_busy", 64'(bus.busy), 64'd0);
    mon_en = 1'b1;

    // randomized traffic, commits biased toward reserved registers
    for (int n = 0; n < 600; n++) begin
      iv = 1'($urandom_range(0, 1));
      ia = int'($urandom_range(0, NUM_REGS - 1));
      cv = ($urandom_range(0, 2) != 0);
      r  = int'($urandom_range(0, 9));
      ca = int'($urandom_range(0, NUM_REGS - 1));
      if (r == 7) begin
        ca = ia;
      end else if (r < 7) begin
        start = int'($urandom_range(0, NUM_REGS - 1));
        for (int k = 0; k < NUM_REGS; k++) begin
          if (mbusy[(start + k) % NUM_REGS]) begin
            ca = (start + k) % NUM_REGS;
            break;
          end
        end
      end
      step(iv, ia, cv, ca);
    end
    step(1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0);
    @(posedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
